toggle_event_counter: RTL and testbench

- Downstream consumer of the cascaded T flip-flop divider output `q`.
- Counts edges of the divided toggle stream (`tin`) over a programmable window of clock cycles.
- Presents the result on a single-entry valid/ready output holding register.
- Used to check divider ratio and activity rate against the `data` strobe rate.

---
 rtl/toggle_event_counter_if.sv | 24 ++
 rtl/toggle_event_counter.sv | 103 ++++++++++
 tb/tb_toggle_event_counter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_event_counter_if.sv
// Result handshake bundle for toggle_event_counter.
// The master side presents the count; the slave side accepts it.
interface toggle_event_counter_if #(
  parameter int CW = 8
);
  logic [CW-1:0] cnt_out;
  logic          cnt_valid;
  logic          ovf;
  logic          out_ready;

  modport master (
    output cnt_out,
    output cnt_valid,
    output ovf,
    input  out_ready
  );

  modport slave (
    input  cnt_out,
    input  cnt_valid,
    input  ovf,
    output out_ready
  );
endinterface

// File: rtl/toggle_event_counter.sv
// Counts tin edges over a programmable window and holds the result.
// TEC_BOTH_EDGES_EN: count rising and falling edges instead of rising only.
module toggle_event_counter #(
  parameter int CW = 8,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tin,
  input  logic          start,
  input  logic [WW-1:0] win_len,
  output logic          busy,
  toggle_event_counter_if.master res
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic          tin_d;
  logic [CW-1:0] cnt;
  logic [WW-1:0] remain;
  logic [CW-1:0] cnt_out_q;
  logic          cnt_valid_q;
  logic          ovf_q;

  logic          tgl;
  logic          sat;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_nxt;

`ifdef TEC_BOTH_EDGES_EN
  assign tgl = tin ^ tin_d;
`else
  assign tgl = tin & ~tin_d;
`endif

  always_comb begin
    sat     = (cnt == {CW{1'b1}});
    cnt_nxt = cnt;
    ovf_nxt = ovf_q;
    if (tgl) begin
      if (sat) ovf_nxt = 1'b1;
      else     cnt_nxt = cnt + 1'b1;
    end
  end

  assign res.cnt_out   = cnt_out_q;
  assign res.cnt_valid = cnt_valid_q;
  assign res.ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tin_d       <= 1'b0;
      cnt         <= '0;
      remain      <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      busy        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tin_d <= tin;
      unique case (state)
        IDLE: begin
          if (start) begin
            // A zero length still runs one cycle.
            remain <= (win_len == '0) ? WW'(1) : win_len;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            state  <= COUNT;
            busy   <= 1'b1;
          end
        end
        COUNT: begin
          cnt    <= cnt_nxt;
          ovf_q  <= ovf_nxt;
          remain <= remain - 1'b1;
          if (remain == WW'(1)) begin
            cnt_out_q   <= cnt_nxt;
            cnt_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (res.out_ready && cnt_valid_q) begin
            cnt_valid_q <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_event_counter.sv
// Directed bench for toggle_event_counter (default and CW=3 instances).
// Both instances share all stimulus; each test checks the relevant one.
module tb_toggle_event_counter;

`ifdef TEC_BOTH_EDGES_EN
  localparam int EXP_BASIC = 8;
  localparam int EXP_BP    = 4;
  localparam int EXP_W40   = 40;
`else
  localparam int EXP_BASIC = 4;
  localparam int EXP_BP    = 2;
  localparam int EXP_W40   = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tin = 1'b0;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        out_ready = 1'b0;
  logic        busy8;
  logic        busy3;

  int cmp  = 0;
  int mism = 0;

  toggle_event_counter_if #(.CW(8)) bus8 ();
  toggle_event_counter_if #(.CW(3)) bus3 ();

  assign bus8.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  toggle_event_counter #(.CW(8), .WW(16)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .tin     (tin),
    .start   (start),
    .win_len (win_len),
    .busy    (busy8),
    .res     (bus8.master)
  );

  toggle_event_counter #(.CW(3), .WW(16)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .tin     (tin),
    .start   (start),
    .win_len (win_len),
    .busy    (busy3),
    .res     (bus3.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tin = ~tin;
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    cmp++;
    if (bus8.cnt_valid !== 1'b0) begin
      mism++;
      $display("FAIL reset_valid: got %b want 0", bus8.cnt_valid);
    end
    cmp++;
    if (busy8 !== 1'b0) begin
      mism++;
      $display("FAIL reset_busy: got %b want 0", busy8);
    end
    cmp++;
    if (bus8.ovf !== 1'b0) begin
      mism++;
      $display("FAIL reset_ovf: got %b want 0", bus8.ovf);
    end
    cmp++;
    if (bus8.cnt_out !== 8'd0) begin
      mism++;
      $display("FAIL reset_cnt: got %0d want 0", bus8.cnt_out);
    end
    step();
    cmp++;
    if (busy8 !== 1'b0) begin
      mism++;
      $display("FAIL reset_idle: got busy %b want 0", busy8);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    tin       = 1'b0;
    win_len   = 16'd8;
    start     = 1'b1;
    step();
    start = 1'b0;
    tin   = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      tin = ~tin;
      if (j == 7) begin
        cmp++;
        if (bus8.cnt_valid !== 1'b0 || busy8 !== 1'b1) begin
          mism++;
          $display("FAIL basic_early: got valid %b busy %b want 0 1",
                   bus8.cnt_valid, busy8);
        end
      end
    end
    cmp++;
    if (bus8.cnt_valid !== 1'b1) begin
      mism++;
      $display("FAIL basic_valid: got %b want 1", bus8.cnt_valid);
    end
    cmp++;
    if (bus8.cnt_out !== 8'(EXP_BASIC)) begin
      mism++;
      $display("FAIL basic_cnt: got %0d want %0d", bus8.cnt_out, EXP_BASIC);
    end
    cmp++;
    if (bus8.ovf !== 1'b0) begin
      mism++;
      $display("FAIL basic_ovf: got %b want 0", bus8.ovf);
    end
    step();
    cmp++;
    if (bus8.cnt_valid !== 1'b0 || busy8 !== 1'b0) begin
      mism++;
      $display("FAIL basic_drop: got valid %b busy %b want 0 0",
               bus8.cnt_valid, busy8);
    end
    cmp++;
    if (bus8.cnt_out !== 8'(EXP_BASIC)) begin
      mism++;
      $display("FAIL basic_keep: got %0d want %0d", bus8.cnt_out, EXP_BASIC);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    tin       = 1'b0;
    win_len   = 16'd40;
    start     = 1'b1;
    step();
    start = 1'b0;
    tin   = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      tin = ~tin;
    end
    cmp++;
    if (bus3.cnt_valid !== 1'b1 || bus3.cnt_out !== 3'd7) begin
      mism++;
      $display("FAIL sat_cnt: got valid %b cnt %0d want 1 7",
               bus3.cnt_valid, bus3.cnt_out);
    end
    cmp++;
    if (bus3.ovf !== 1'b1) begin
      mism++;
      $display("FAIL sat_ovf: got %b want 1", bus3.ovf);
    end
    cmp++;
    if (bus8.cnt_out !== 8'(EXP_W40) || bus8.ovf !== 1'b0) begin
      mism++;
      $display("FAIL sat_wide: got cnt %0d ovf %b want %0d 0",
               bus8.cnt_out, bus8.ovf, EXP_W40);
    end
    step();
    tin     = 1'b0;
    win_len = 16'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 4; j++) step();
    cmp++;
    if (bus3.cnt_valid !== 1'b1 || bus3.cnt_out !== 3'd0) begin
      mism++;
      $display("FAIL sat_next_cnt: got valid %b cnt %0d want 1 0",
               bus3.cnt_valid, bus3.cnt_out);
    end
    cmp++;
    if (bus3.ovf !== 1'b0) begin
      mism++;
      $display("FAIL sat_next_ovf: got %b want 0", bus3.ovf);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    tin       = 1'b0;
    win_len   = 16'd4;
    start     = 1'b1;
    step();
    start = 1'b0;
    tin   = 1'b1;
    step();
    tin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    tin   = 1'b1;
    step();
    tin = 1'b0;
    step();
    cmp++;
    if (bus8.cnt_valid !== 1'b1 || bus8.cnt_out !== 8'(EXP_BP)) begin
      mism++;
      $display("FAIL bp_result: got valid %b cnt %0d want 1 %0d",
               bus8.cnt_valid, bus8.cnt_out, EXP_BP);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tin   = ~tin;
      step();
      cmp++;
      if (bus8.cnt_valid !== 1'b1 || bus8.cnt_out !== 8'(EXP_BP) ||
          bus8.ovf !== 1'b0 || busy8 !== 1'b1) begin
        mism++;
        $display("FAIL bp_hold%0d: got v%b c%0d o%b b%b want v1 c%0d o0 b1",
                 i, bus8.cnt_valid, bus8.cnt_out, bus8.ovf, busy8, EXP_BP);
      end
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    cmp++;
    if (bus8.cnt_valid !== 1'b0 || busy8 !== 1'b0) begin
      mism++;
      $display("FAIL bp_release: got valid %b busy %b want 0 0",
               bus8.cnt_valid, busy8);
    end
    for (int i = 0; i < 3; i++) step();
    cmp++;
    if (busy8 !== 1'b0 || bus8.cnt_valid !== 1'b0) begin
      mism++;
      $display("FAIL bp_no_extra: got busy %b valid %b want 0 0",
               busy8, bus8.cnt_valid);
    end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    tin       = 1'b0;
    step();
    win_len = 16'd0;
    start   = 1'b1;
    step();
    start = 1'b0;
    tin   = 1'b1;
    step();
    cmp++;
    if (bus8.cnt_valid !== 1'b1 || bus8.cnt_out !== 8'd1) begin
      mism++;
      $display("FAIL zero_len: got valid %b cnt %0d want 1 1",
               bus8.cnt_valid, bus8.cnt_out);
    end
    step();
    cmp++;
    if (busy8 !== 1'b0) begin
      mism++;
      $display("FAIL zero_len_done: got busy %b want 0", busy8);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b1;
    win_len   = 16'd100;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tin = ~tin;
      step();
    end
    cmp++;
    if (busy8 !== 1'b1) begin
      mism++;
      $display("FAIL mid_busy: got %b want 1", busy8);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp++;
    if (busy8 !== 1'b0 || bus8.cnt_valid !== 1'b0 || bus8.cnt_out !== 8'd0) begin
      mism++;
      $display("FAIL mid_reset: got busy %b valid %b cnt %0d want 0 0 0",
               busy8, bus8.cnt_valid, bus8.cnt_out);
    end
    seen = 1'b0;
    for (int j = 0; j < 110; j++) begin
      tin = ~tin;
      step();
      if (bus8.cnt_valid !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
    end
    cmp++;
    if (seen !== 1'b0) begin
      mism++;
      $display("FAIL mid_no_result: got activity %b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
